// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage bus between the next-PC controller, the history buffer/target store and EX.
// master = the controller side, slave = the environment (predictors, hazard unit, EX).
interface fetch_pc_ctrl_if #(parameter int PC_W = 30);
    logic            stall_f;
    logic            stall_d;
    logic            bhb_valid;
    logic            bhb_taken;
    logic            btb_hit;
    logic [PC_W-1:0] btb_target;
    logic            ex_is_branch;
    logic            ex_taken;
    logic [PC_W-1:0] ex_target;
    logic [PC_W-1:0] pc_if;
    logic            pred_taken_if;
    logic            flush;
    logic [PC_W-1:0] redirect_pc;
    logic            bhb_update;

    modport master (
        input  stall_f, stall_d, bhb_valid, bhb_taken, btb_hit, btb_target,
               ex_is_branch, ex_taken, ex_target,
        output pc_if, pred_taken_if, flush, redirect_pc, bhb_update
    );

    modport slave (
        output stall_f, stall_d, bhb_valid, bhb_taken, btb_hit, btb_target,
               ex_is_branch, ex_taken, ex_target,
        input  pc_if, pred_taken_if, flush, redirect_pc, bhb_update
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Next-PC generator: predicts from the history buffer, tracks predictions through ID/EX, flushes on mispredict.
// Optional FETCH_PRED_STATS_EN adds saturating branch / mispredict counters.
module fetch_pc_ctrl #(
    parameter int              PC_W     = 30,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rstn,
    fetch_pc_ctrl_if.master  bus
`ifdef FETCH_PRED_STATS_EN
    ,
    output logic [31:0]      br_count,
    output logic [31:0]      mispred_count
`endif
);
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } slot_t;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [PC_W-1:0] pc_q, pc_d;
    slot_t           id_q, id_d;
    slot_t           ex_q, ex_d;
    logic            pred_taken;
    logic            ex_br;
    logic            mispred;
    logic [PC_W-1:0] redirect;

    always_comb begin
        pred_taken = bus.bhb_valid & bus.bhb_taken & bus.btb_hit;
        ex_br      = ex_q.valid & bus.ex_is_branch;
        // A prediction on a non-branch means the history entry aliased; treat as mispredict.
        mispred    = (ex_br & ((bus.ex_taken != ex_q.pred_taken) |
                               (bus.ex_taken & ex_q.pred_taken & (bus.ex_target != ex_q.pred_target)))) |
                     (ex_q.valid & ~bus.ex_is_branch & ex_q.pred_taken);
        redirect   = '0;
        if (mispred)
            redirect = (bus.ex_is_branch & bus.ex_taken) ? bus.ex_target : ex_q.pc + PC_ONE;
    end

    always_comb begin
        pc_d = pc_q + PC_ONE;
        if (mispred)         pc_d = redirect;
        else if (bus.stall_f) pc_d = pc_q;
        else if (pred_taken)  pc_d = bus.btb_target;

        id_d = '{valid: 1'b1, pc: pc_q, pred_taken: pred_taken, pred_target: bus.btb_target};
        if (mispred)          id_d = '0;
        else if (bus.stall_d) id_d = id_q;
        else if (bus.stall_f) id_d = '0;

        ex_d = id_q;
        if (mispred || bus.stall_d) ex_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q <= RESET_PC;
            id_q <= '0;
            ex_q <= '0;
        end else begin
            pc_q <= pc_d;
            id_q <= id_d;
            ex_q <= ex_d;
        end
    end

    assign bus.pc_if         = pc_q;
    assign bus.pred_taken_if = pred_taken;
    assign bus.flush         = mispred;
    assign bus.redirect_pc   = redirect;
    assign bus.bhb_update    = ex_br;

`ifdef FETCH_PRED_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (ex_br && br_cnt_q != 32'hFFFF_FFFF)    br_cnt_d  = br_cnt_q + 32'd1;
        if (mispred && mis_cnt_q != 32'hFFFF_FFFF) mis_cnt_d = mis_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: per-cycle expectations queued by the driver, checked at negedge.
module tb_fetch_pc_ctrl;
    localparam int PC_W = 30;

    logic clk = 1'b0;
    logic rstn;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl_if #(.PC_W(PC_W)) bus ();

`ifdef FETCH_PRED_STATS_EN
    logic [31:0] br_count, mispred_count;
`endif

    fetch_pc_ctrl #(.PC_W(PC_W), .RESET_PC(30'h100)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .bus           (bus)
`ifdef FETCH_PRED_STATS_EN
        ,
        .br_count      (br_count),
        .mispred_count (mispred_count)
`endif
    );

    typedef struct {
        string           tag;
        logic [PC_W-1:0] pc;
        logic            pr;
        logic            fl;
        logic [PC_W-1:0] rd;
        logic            up;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".pc"},    32'(bus.pc_if),         32'(e.pc));
            chk({e.tag, ".pred"},  32'(bus.pred_taken_if), 32'(e.pr));
            chk({e.tag, ".flush"}, 32'(bus.flush),         32'(e.fl));
            chk({e.tag, ".rdpc"},  32'(bus.redirect_pc),   32'(e.rd));
            chk({e.tag, ".upd"},   32'(bus.bhb_update),    32'(e.up));
        end
    end

    // pv = {bhb_valid, bhb_taken, btb_hit}; expectations describe the current cycle.
    task automatic step(input string tag, input bit sf, input bit sd,
                        input logic [2:0] pv, input logic [PC_W-1:0] tgt,
                        input bit eb, input bit et, input logic [PC_W-1:0] etg,
                        input logic [PC_W-1:0] pc, input bit fl,
                        input logic [PC_W-1:0] rd, input bit up);
        exp_t e;
        bus.stall_f      = sf;
        bus.stall_d      = sd;
        bus.bhb_valid    = pv[2];
        bus.bhb_taken    = pv[1];
        bus.btb_hit      = pv[0];
        bus.btb_target   = tgt;
        bus.ex_is_branch = eb;
        bus.ex_taken     = et;
        bus.ex_target    = etg;
        e.tag = tag; e.pc = pc; e.pr = &pv; e.fl = fl; e.rd = rd; e.up = up;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        bus.stall_f = 0; bus.stall_d = 0; bus.bhb_valid = 0; bus.bhb_taken = 0;
        bus.btb_hit = 0; bus.btb_target = '0; bus.ex_is_branch = 0; bus.ex_taken = 0;
        bus.ex_target = '0;
        do_reset();

        step("rst0",   0,0, 3'b000,30'h0,   0,0,30'h0,   30'h100, 0,30'h0,   0);
        step("seq1",   0,0, 3'b000,30'h0,   0,0,30'h0,   30'h101, 0,30'h0,   0);
        step("seq2",   0,0, 3'b000,30'h0,   0,0,30'h0,   30'h102, 0,30'h0,   0);
        step("nohit",  0,0, 3'b110,30'h3AA, 0,0,30'h0,   30'h103, 0,30'h0,   0);
        step("pred",   0,0, 3'b111,30'h200, 0,0,30'h0,   30'h104, 0,30'h0,   0);
        step("tgt",    0,0, 3'b000,30'h0,   0,0,30'h0,   30'h200, 0,30'h0,   0);
        step("okres",  0,0, 3'b000,30'h0,   1,1,30'h200, 30'h201, 0,30'h0,   1);
        step("okpost", 0,0, 3'b000,30'h0,   0,0,30'h0,   30'h202, 0,30'h0,   0);

        do_reset();
        step("r_ign0", 0,0, 3'b000,30'h0,   1,1,30'h333, 30'h100, 0,30'h0,   0);
        step("r_ign1", 0,0, 3'b000,30'h0,   1,1,30'h333, 30'h101, 0,30'h0,   0);
        step("r2",     0,0, 3'b000,30'h0,   0,0,30'h0,   30'h102, 0,30'h0,   0);
        step("r3",     0,0, 3'b000,30'h0,   0,0,30'h0,   30'h103, 0,30'h0,   0);
        step("r_pred", 0,0, 3'b111,30'h200, 0,0,30'h0,   30'h104, 0,30'h0,   0);
        step("r_tgt",  0,0, 3'b000,30'h0,   0,0,30'h0,   30'h200, 0,30'h0,   0);
        step("nt_mis", 0,0, 3'b000,30'h0,   1,0,30'h0,   30'h201, 1,30'h105, 1);
        step("bub1",   0,0, 3'b000,30'h0,   1,1,30'h333, 30'h105, 0,30'h0,   0);
        step("bub2",   0,0, 3'b000,30'h0,   1,1,30'h333, 30'h106, 0,30'h0,   0);
        step("refill", 0,0, 3'b000,30'h0,   0,0,30'h0,   30'h107, 0,30'h0,   0);
        step("s108",   0,0, 3'b000,30'h0,   0,0,30'h0,   30'h108, 0,30'h0,   0);
        step("s109",   0,0, 3'b000,30'h0,   0,0,30'h0,   30'h109, 0,30'h0,   0);
        step("tk_mis", 0,0, 3'b000,30'h0,   1,1,30'h300, 30'h10A, 1,30'h300, 1);
        step("p300",   0,0, 3'b111,30'h200, 0,0,30'h0,   30'h300, 0,30'h0,   0);
        step("p200",   0,0, 3'b000,30'h0,   0,0,30'h0,   30'h200, 0,30'h0,   0);
        step("tg_mis", 0,0, 3'b000,30'h0,   1,1,30'h204, 30'h201, 1,30'h204, 1);
        step("p204",   0,0, 3'b000,30'h0,   0,0,30'h0,   30'h204, 0,30'h0,   0);
        step("p205",   0,0, 3'b000,30'h0,   0,0,30'h0,   30'h205, 0,30'h0,   0);
        step("st_mis", 1,1, 3'b000,30'h0,   1,1,30'h400, 30'h206, 1,30'h400, 1);
        step("st_h1",  1,1, 3'b000,30'h0,   0,0,30'h0,   30'h400, 0,30'h0,   0);
        step("st_h2",  1,1, 3'b000,30'h0,   0,0,30'h0,   30'h400, 0,30'h0,   0);
        step("st_end", 0,0, 3'b000,30'h0,   0,0,30'h0,   30'h400, 0,30'h0,   0);
        step("sd_only",0,1, 3'b000,30'h0,   0,0,30'h0,   30'h401, 0,30'h0,   0);
        step("sd_bub", 0,0, 3'b000,30'h0,   1,1,30'h555, 30'h402, 0,30'h0,   0);
        step("sd_held",0,0, 3'b000,30'h0,   1,0,30'h0,   30'h403, 0,30'h0,   1);
        step("p_wrap", 0,0, 3'b111,30'h3FFF_FFFF, 0,0,30'h0, 30'h404, 0,30'h0, 0);
        step("pmax",   0,0, 3'b000,30'h0,   0,0,30'h0,   30'h3FFF_FFFF, 0,30'h0, 0);
        step("alias",  0,0, 3'b000,30'h0,   0,0,30'h0,   30'h0,   1,30'h405, 0);
        step("a_post", 0,0, 3'b000,30'h0,   0,0,30'h0,   30'h405, 0,30'h0,   0);

        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
`ifdef FETCH_PRED_STATS_EN
        chk("br_count",      br_count,      32'd5);
        chk("mispred_count", mispred_count, 32'd5);
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
